// File: rtl/mem_port_ctrl.sv
// Single-outstanding data-memory port: arbitrates a load and a store requester onto one memory command.
// Define MEMCTRL_RR_ARB_EN for round-robin arbitration; the default is fixed load-first priority.
module mem_port_ctrl #(
    parameter int WIDTH    = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [ADDR_LEN-1:0] ld_addr,
    input  logic [3:0]          ld_tag,
    input  logic                st_valid,
    output logic                st_ready,
    input  logic [ADDR_LEN-1:0] st_addr,
    input  logic [WIDTH-1:0]    st_data,
    input  logic [3:0]          st_be,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [WIDTH-1:0]    mem_wdata,
    output logic [3:0]          mem_be,
    input  logic                mem_ack,
    input  logic [WIDTH-1:0]    mem_rdata,
    output logic                ld_resp_valid,
    output logic [WIDTH-1:0]    ld_resp_data,
    output logic [3:0]          ld_resp_tag,
    output logic                st_done,
    output logic                busy
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t     state_q;
    state_t     state_d;
    logic       grant_ld;
    logic       grant_st;
    logic       ld_first;
    logic [3:0] tag_p0;

`ifdef MEMCTRL_RR_ARB_EN
    // Pointer names the type that wins the next tie; it moves only on a handshake.
    logic ld_first_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_first_q <= 1'b1;
        end else if (grant_ld) begin
            ld_first_q <= 1'b0;
        end else if (grant_st) begin
            ld_first_q <= 1'b1;
        end
    end

    assign ld_first = ld_first_q;
`else
    assign ld_first = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grants double as handshake strobes: only the granted side sees ready.
    always_comb begin
        state_d  = state_q;
        grant_ld = 1'b0;
        grant_st = 1'b0;
        if (state_q == IDLE) begin
            grant_ld = ld_valid && (!st_valid || ld_first);
            grant_st = st_valid && !grant_ld;
            if (grant_ld || grant_st) begin
                state_d = WAIT;
            end
        end else if (mem_ack) begin
            state_d = IDLE;
        end
    end

    assign ld_ready = grant_ld && !reset;
    assign st_ready = grant_st && !reset;
    assign mem_req  = (state_q == WAIT);
    assign busy     = (state_q == WAIT);

    // Command capture at the handshake, completion pulses one cycle after the ack edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_be        <= '0;
            tag_p0        <= '0;
            ld_resp_valid <= 1'b0;
            ld_resp_data  <= '0;
            ld_resp_tag   <= '0;
            st_done       <= 1'b0;
        end else begin
            ld_resp_valid <= 1'b0;
            st_done       <= 1'b0;
            if (grant_ld) begin
                mem_we    <= 1'b0;
                mem_addr  <= ld_addr;
                mem_wdata <= '0;
                mem_be    <= '0;
                tag_p0    <= ld_tag;
            end else if (grant_st) begin
                mem_we    <= 1'b1;
                mem_addr  <= st_addr;
                mem_wdata <= st_data;
                mem_be    <= st_be;
            end
            if ((state_q == WAIT) && mem_ack) begin
                if (mem_we) begin
                    st_done <= 1'b1;
                end else begin
                    ld_resp_valid <= 1'b1;
                    ld_resp_data  <= mem_rdata;
                    ld_resp_tag   <= tag_p0;
                end
            end
        end
    end

endmodule

// File: doc/mem_port_ctrl.md
MEM_PORT_CTRL -- requirements
Module: mem_port_ctrl

Interface
REQ-001 SHALL have parameters: WIDTH, 32, data width; ADDR_LEN, 32, address width.
REQ-002 SHALL have port: clk  in  1  single clock, rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: ld_valid in 1, ld_ready out 1, ld_addr in ADDR_LEN, ld_tag in 4  load request channel.
REQ-005 SHALL have ports: st_valid in 1, st_ready out 1, st_addr in ADDR_LEN, st_data in WIDTH, st_be in 4  store request channel.
REQ-006 SHALL have ports: mem_req out 1, mem_we out 1, mem_addr out ADDR_LEN, mem_wdata out WIDTH, mem_be out 4  data-memory command.
REQ-007 SHALL have ports: mem_ack in 1, mem_rdata in WIDTH  memory completion pulse and read data.
REQ-008 SHALL have ports: ld_resp_valid out 1, ld_resp_data out WIDTH, ld_resp_tag out 4  load response to the MEM-WB register.
REQ-009 SHALL have ports: st_done out 1  store completion pulse; busy out 1  access in flight.

Function
REQ-010 SHALL implement FSM states IDLE and WAIT; at most one memory access outstanding.
REQ-011 In IDLE, SHALL assert ld_ready/st_ready combinationally only for the granted requester; the other ready stays 0.
REQ-012 In WAIT, SHALL drive ld_ready=0 and st_ready=0.
REQ-013 Handshake at edge where granted valid&ready=1: SHALL latch addr/data/be/tag/type and enter WAIT.
REQ-014 In WAIT, SHALL hold mem_req=1 with registered, stable mem_addr/mem_we/mem_wdata/mem_be until mem_ack sampled high.
REQ-015 mem_we SHALL be 1 for store, 0 for load; mem_wdata and mem_be SHALL be 0 for loads.
REQ-016 Edge with mem_req=1 and mem_ack=1: SHALL return to IDLE and deassert mem_req next cycle.
REQ-017 On load completion, SHALL drive ld_resp_valid=1 for exactly one cycle next cycle, with ld_resp_data=mem_rdata sampled at the ack edge and ld_resp_tag=latched tag.
REQ-018 On store completion, SHALL pulse st_done for exactly one cycle next cycle.
REQ-019 Minimum latency: accept T, mem_req T+1, mem_ack in T+1, response T+2.
REQ-020 SHALL ignore mem_ack while mem_req=0.
REQ-021 SHALL accept a new request in the same cycle a response pulse is driven (back-to-back: one access per 2 cycles minimum).
REQ-022 busy SHALL equal (state==WAIT).
REQ-023 Requester deasserting valid without handshake SHALL have no effect; no request is lost once the handshake completes.

Reset
REQ-024 reset=1 SHALL immediately (asynchronously) force IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, ld_resp_valid=0, ld_resp_data=0, ld_resp_tag=0, st_done=0, busy=0, arbitration pointer=load.
REQ-025 An access in flight at reset SHALL be discarded; no response or st_done SHALL be produced for it, and a late mem_ack SHALL be ignored.
REQ-026 ld_ready/st_ready SHALL be 0 while reset=1.

Configuration
REQ-027 Macro MEMCTRL_RR_ARB_EN SHALL select arbitration policy.
REQ-028 Without MEMCTRL_RR_ARB_EN: fixed priority, load wins when both valid in IDLE.
REQ-029 With MEMCTRL_RR_ARB_EN: round-robin; when both valid, grant the type not granted at the last handshake; pointer updates only on handshake; after reset, load wins first.

Verification
REQ-030 Load ld_addr=0x100, tag=3, mem_ack 2 cycles after mem_req rises, mem_rdata=0xDEADBEEF -> one-cycle ld_resp_valid, data 0xDEADBEEF, tag 3; mem_we=0 throughout.
REQ-031 Store st_addr=0x40, st_data=0x12345678, st_be=4'b0011, ack same cycle as mem_req -> mem_we=1, mem_be=0011, st_done pulse at T+2.
REQ-032 Both valid in IDLE for 4 requests each -> fixed build: 4 loads then 4 stores; MEMCTRL_RR_ARB_EN build: L,S,L,S,L,S,L,S.
REQ-033 reset pulsed 1 cycle while WAIT (load tag 5), then mem_ack asserted -> mem_req drops during reset, no ld_resp_valid, busy=0.
REQ-034 mem_ack pulses while IDLE, then valid load -> spurious acks ignored, load waits for its own ack.
REQ-035 Ack of load and new store valid in following cycle -> ld_resp_valid and st_ready both 1 in that cycle; store issues next cycle.
